// File: rtl/pl_reg_de_skid.sv
// rtl/pl_reg_de_skid.sv - D/E pipeline register with one-entry skid buffer, flush and stall counter
module pl_reg_de_skid #(
   parameter int DATA_W = 32,
   parameter int N_DATA = 4,
   parameter int CTRL_W = 4,
   parameter int RD_W   = 5,
   parameter int ALUC_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_DATA*DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0]        in_ctrl,
   input  logic [RD_W-1:0]          in_rd,
   input  logic [ALUC_W-1:0]        in_aluc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_DATA*DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [RD_W-1:0]          out_rd,
   output logic [ALUC_W-1:0]        out_aluc,
   output logic [CNT_W-1:0]         stall_cnt
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t state, state_nx;

   logic                     in_ready_r;
   logic                     accept, consume;
   logic                     load_main, main_from_skid, load_skid;

   logic [N_DATA*DATA_W-1:0] main_data, skid_data;
   logic [CTRL_W-1:0]        main_ctrl, skid_ctrl;
   logic [RD_W-1:0]          main_rd, skid_rd;
   logic [ALUC_W-1:0]        main_aluc, skid_aluc;
   logic [CNT_W-1:0]         cnt;

   assign in_ready  = in_ready_r;
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready_r;
   assign consume   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= EMPTY;
         in_ready_r <= 1'b1;
      end else begin
         state      <= state_nx;
         in_ready_r <= (state_nx != TWO);
      end
   end

   // flush wins over any handshake; an input offered in the flush cycle is dropped
   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (accept) state_nx = ONE;
            ONE: begin
               if (accept && !consume)      state_nx = TWO;
               else if (consume && !accept) state_nx = EMPTY;
            end
            TWO:     if (consume) state_nx = ONE;
            default: state_nx = EMPTY;
         endcase
      end
   end

   always_comb begin
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (!flush) begin
         case (state)
            EMPTY: load_main = accept;
            ONE: begin
               load_main = accept && consume;
               load_skid = accept && !consume;
            end
            TWO:     main_from_skid = consume;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         main_data <= '0;
         main_ctrl <= '0;
         main_rd   <= '0;
         main_aluc <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
         skid_rd   <= '0;
         skid_aluc <= '0;
      end else begin
         if (load_main) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            main_rd   <= in_rd;
            main_aluc <= in_aluc;
         end else if (main_from_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            main_rd   <= skid_rd;
            main_aluc <= skid_aluc;
         end
         if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            skid_rd   <= in_rd;
            skid_aluc <= in_aluc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (out_valid && !out_ready && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

   // bubbles must never carry write enables or a destination register
   assign out_data  = main_data;
   assign out_aluc  = main_aluc;
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign out_rd    = out_valid ? main_rd : '0;
   assign stall_cnt = cnt;

endmodule

// File: tb/tb_pl_reg_de_skid.sv
// tb/tb_pl_reg_de_skid.sv - randomized and directed bench for pl_reg_de_skid against a queue model
module tb_pl_reg_de_skid;

   localparam int DW = 32;
   localparam int ND = 4;
   localparam int EW = DW*ND + 4 + 5 + 5;

   logic            clk = 1'b0;
   logic            clr, flush, in_valid, out_ready;
   logic [DW*ND-1:0] in_data;
   logic [3:0]      in_ctrl;
   logic [4:0]      in_rd, in_aluc;

   logic            in_ready, out_valid;
   logic [DW*ND-1:0] out_data;
   logic [3:0]      out_ctrl;
   logic [4:0]      out_rd, out_aluc;
   logic [15:0]     stall_cnt;

   logic            s_in_ready, s_out_valid;
   logic [DW*ND-1:0] s_out_data;
   logic [3:0]      s_out_ctrl;
   logic [4:0]      s_out_rd, s_out_aluc;
   logic [2:0]      s_stall_cnt;

   int vectors = 0;
   int miscompares = 0;

   logic [EW-1:0] q[$];
   int            exp_cnt;
   int            exp_cnt_s;

   always #5 clk = ~clk;

   pl_reg_de_skid dut (
      .clk(clk), .clr(clr), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_ctrl(in_ctrl), .in_rd(in_rd), .in_aluc(in_aluc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ctrl(out_ctrl), .out_rd(out_rd), .out_aluc(out_aluc),
      .stall_cnt(stall_cnt)
   );

   pl_reg_de_skid #(.CNT_W(3)) dut_s (
      .clk(clk), .clr(clr), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .in_ctrl(in_ctrl), .in_rd(in_rd), .in_aluc(in_aluc),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_ctrl(s_out_ctrl), .out_rd(s_out_rd), .out_aluc(s_out_aluc),
      .stall_cnt(s_stall_cnt)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [EW-1:0] e;
      check("in_ready", 128'(in_ready), 128'(q.size() < 2));
      check("out_valid", 128'(out_valid), 128'(q.size() > 0));
      if (q.size() > 0) begin
         e = q[0];
         check("out_data", 128'(out_data), 128'(e[EW-1 -: DW*ND]));
         check("out_ctrl", 128'(out_ctrl), 128'(e[13:10]));
         check("out_rd", 128'(out_rd), 128'(e[9:5]));
         check("out_aluc", 128'(out_aluc), 128'(e[4:0]));
      end else begin
         check("bubble_ctrl", 128'(out_ctrl), 128'(0));
         check("bubble_rd", 128'(out_rd), 128'(0));
      end
      check("stall_cnt", 128'(stall_cnt), 128'(exp_cnt));
      check("stall_cnt_sat", 128'(s_stall_cnt), 128'(exp_cnt_s));
   endtask

   // one clock: drive at negedge, advance the FIFO model, sample 1 time unit after the edge
   task automatic step(input logic c, input logic f, input logic iv, input logic [DW*ND-1:0] d,
                       input logic [3:0] ct, input logic [4:0] r, input logic [4:0] al,
                       input logic ordy);
      logic m_rdy, m_val;
      @(negedge clk);
      clr = c; flush = f; in_valid = iv; in_data = d;
      in_ctrl = ct; in_rd = r; in_aluc = al; out_ready = ordy;
      m_rdy = (q.size() < 2);
      m_val = (q.size() > 0);
      if (c) begin
         q.delete();
         exp_cnt = 0;
         exp_cnt_s = 0;
      end else begin
         if (m_val && !ordy) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt_s < 7) exp_cnt_s++;
         end
         if (f) begin
            q.delete();
         end else begin
            if (m_val && ordy) void'(q.pop_front());
            if (iv && m_rdy) q.push_back({d, ct, r, al});
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic push(input logic [31:0] w0, input logic ordy);
      step(1'b0, 1'b0, 1'b1, {96'h0, w0}, 4'h5, 5'd7, 5'd3, ordy);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, 1'b0, '0, 4'h0, 5'd0, 5'd0, ordy);
   endtask

   task automatic reset1();
      step(1'b1, 1'b0, 1'b0, '0, 4'h0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0; in_rd = '0; in_aluc = '0;
      exp_cnt = 0; exp_cnt_s = 0;

      // reset with a live input offered
      step(1'b1, 1'b0, 1'b1, '1, 4'hF, 5'h1F, 5'h1F, 1'b0);
      step(1'b1, 1'b0, 1'b1, '1, 4'hF, 5'h1F, 5'h1F, 1'b0);
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_stall", 128'(stall_cnt), 128'(0));
      check("rst_out_data", 128'(out_data), 128'(0));
      check("rst_out_aluc", 128'(out_aluc), 128'(0));

      // streaming
      push(32'h100, 1'b1);
      check("stream0", 128'(out_data[31:0]), 128'(32'h100));
      push(32'h104, 1'b1);
      check("stream1", 128'(out_data[31:0]), 128'(32'h104));
      push(32'h108, 1'b1);
      check("stream2", 128'(out_data[31:0]), 128'(32'h108));
      idle(1'b1);
      check("stream_stall", 128'(stall_cnt), 128'(0));

      // back-pressure into the skid
      reset1();
      push(32'hA, 1'b0);
      push(32'hB, 1'b0);
      check("skid_full", 128'(in_ready), 128'(0));
      push(32'hC, 1'b0);
      idle(1'b0);
      check("bp_stall3", 128'(stall_cnt), 128'(3));
      check("bp_headA", 128'(out_data[31:0]), 128'(32'hA));
      idle(1'b1);
      check("bp_B", 128'(out_data[31:0]), 128'(32'hB));
      push(32'hC, 1'b1);
      check("bp_C", 128'(out_data[31:0]), 128'(32'hC));
      idle(1'b1);
      check("bp_drained", 128'(out_valid), 128'(0));

      // flush while full
      push(32'hA, 1'b0);
      push(32'hB, 1'b0);
      step(1'b0, 1'b1, 1'b1, {96'h0, 32'hD}, 4'hF, 5'd9, 5'd1, 1'b0);
      check("fl_valid", 128'(out_valid), 128'(0));
      check("fl_ctrl", 128'(out_ctrl), 128'(0));
      check("fl_rd", 128'(out_rd), 128'(0));
      check("fl_ready", 128'(in_ready), 128'(1));
      idle(1'b1);
      check("fl_no_D", 128'(out_valid), 128'(0));

      // accept and consume together in ONE
      push(32'hA, 1'b1);
      push(32'hB, 1'b1);
      check("sim_B", 128'(out_data[31:0]), 128'(32'hB));
      check("sim_ready", 128'(in_ready), 128'(1));
      idle(1'b1);

      // saturation of the narrow counter
      reset1();
      push(32'h55, 1'b0);
      for (int i = 0; i < 10; i++) idle(1'b0);
      check("sat7", 128'(s_stall_cnt), 128'(7));
      check("wide10", 128'(stall_cnt), 128'(10));
      step(1'b0, 1'b1, 1'b0, '0, 4'h0, 5'd0, 5'd0, 1'b0);
      check("sat_flush", 128'(s_stall_cnt), 128'(7));
      reset1();
      check("sat_clr", 128'(s_stall_cnt), 128'(0));

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
              $urandom_range(0, 1), {$urandom, $urandom, $urandom, $urandom},
              4'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(0, 2) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
